// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state type, width helpers and mask search for reset_sequencer
package reset_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        RELEASE,
        DONE,
        SW_HOLD,
        SW_RELEASE
    } seq_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // A single-domain build still needs a one-bit index register.
    function automatic int idx_width(input int num_domains);
        return (clog2(num_domains) < 1) ? 1 : clog2(num_domains);
    endfunction

    function automatic int cnt_width(input int gap_cycles, input int hold_cycles);
        return clog2(((gap_cycles > hold_cycles) ? gap_cycles : hold_cycles) + 1);
    endfunction

    // Lowest set bit of mask at an index >= start; 16 when there is none.
    function automatic int next_set_bit(input logic [15:0] mask, input int start);
        int r;
        r = 16;
        for (int i = 15; i >= 0; i--) begin
            if (i >= start && mask[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// rtl/rst_sync.sv - reset deassertion synchroniser, async clear, D tied high
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CK,
    input  logic RN,
    output logic rn_sync
);

    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rn_sync = sync[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged per-domain reset release with software reset handshake
module reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                   CK,
    input  logic                   RN,
    input  logic                   sw_req,
    input  logic [NUM_DOMAINS-1:0] sw_mask,
    output logic                   sw_ack,
    output logic                   sw_err,
    output logic [NUM_DOMAINS-1:0] rn_out,
    output logic                   all_released
);
    import reset_seq_pkg::*;

    localparam int IDX_W = idx_width(NUM_DOMAINS);
    localparam int CNT_W = cnt_width(GAP_CYCLES, HOLD_CYCLES);

    seq_state_t             state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [IDX_W-1:0]       idx, idx_d;
    logic [NUM_DOMAINS-1:0] mask, mask_d;
    logic [NUM_DOMAINS-1:0] rn_out_d;
    logic                   all_rel_d, ack_d, err_d;
    logic                   err_pend, err_pend_d;
    logic                   zero_pend, zero_pend_d;
    logic [15:0]            mask16;
    logic                   rn_sync;

    rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
        .CK      (CK),
        .RN      (RN),
        .rn_sync (rn_sync)
    );

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state        <= HOLD;
            cnt          <= '0;
            idx          <= '0;
            mask         <= '0;
            rn_out       <= '0;
            all_released <= 1'b0;
            sw_ack       <= 1'b0;
            sw_err       <= 1'b0;
            err_pend     <= 1'b0;
            zero_pend    <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            idx          <= idx_d;
            mask         <= mask_d;
            rn_out       <= rn_out_d;
            all_released <= all_rel_d;
            sw_ack       <= ack_d;
            sw_err       <= err_d;
            err_pend     <= err_pend_d;
            zero_pend    <= zero_pend_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        idx_d       = idx;
        mask_d      = mask;
        rn_out_d    = rn_out;
        all_rel_d   = all_released;
        // Zero-mask acks and out-of-state errors surface one edge after sampling.
        ack_d       = zero_pend;
        zero_pend_d = 1'b0;
        err_d       = err_pend;
        err_pend_d  = sw_req && (state != DONE);
        mask16      = '0;
        mask16[NUM_DOMAINS-1:0] = mask;

        case (state)
            HOLD: begin
                if (rn_sync) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            RELEASE: begin
                if (&rn_out) begin
                    state_d   = DONE;
                    all_rel_d = 1'b1;
                end else if (cnt == '0) begin
                    rn_out_d[idx] = 1'b1;
                    cnt_d         = CNT_W'(GAP_CYCLES - 1);
                    if (idx != IDX_W'(NUM_DOMAINS - 1)) idx_d = idx + IDX_W'(1);
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (sw_req) begin
                    if (sw_mask == '0) begin
                        zero_pend_d = 1'b1;
                    end else begin
                        mask_d    = sw_mask;
                        rn_out_d  = rn_out & ~sw_mask;
                        all_rel_d = 1'b0;
                        cnt_d     = CNT_W'(HOLD_CYCLES - 1);
                        state_d   = SW_HOLD;
                    end
                end
            end
            SW_HOLD: begin
                if (cnt == '0) begin
                    idx_d           = IDX_W'(next_set_bit(mask16, 0));
                    rn_out_d[idx_d] = 1'b1;
                    cnt_d           = CNT_W'(GAP_CYCLES - 1);
                    state_d         = SW_RELEASE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            SW_RELEASE: begin
                // Unset mask bits are skipped by the search, so they cost no gap.
                if ((rn_out & mask) == mask) begin
                    state_d   = DONE;
                    all_rel_d = 1'b1;
                    ack_d     = 1'b1;
                end else if (cnt == '0) begin
                    idx_d           = IDX_W'(next_set_bit(mask16, int'(idx) + 1));
                    rn_out_d[idx_d] = 1'b1;
                    cnt_d           = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - randomized self-checking bench with a timeline model of reset_sequencer
module tb_reset_sequencer;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int GAP  = 4;
    localparam int HOLD = 4;
    localparam int BIG  = 1 << 30;

    logic         CK;
    logic         RN;
    logic         sw_req;
    logic [N-1:0] sw_mask;
    logic         sw_ack, sw_err, all_released;
    logic [N-1:0] rn_out;

    logic         u1_ack, u1_err, u1_all;
    logic [0:0]   u1_rn;

    int vectors     = 0;
    int miscompares = 0;

    reset_sequencer #(
        .NUM_DOMAINS(N), .SYNC_STAGES(SYNC), .GAP_CYCLES(GAP), .HOLD_CYCLES(HOLD)
    ) dut (
        .CK(CK), .RN(RN), .sw_req(sw_req), .sw_mask(sw_mask),
        .sw_ack(sw_ack), .sw_err(sw_err), .rn_out(rn_out), .all_released(all_released)
    );

    reset_sequencer #(
        .NUM_DOMAINS(1), .SYNC_STAGES(3), .GAP_CYCLES(1), .HOLD_CYCLES(1)
    ) u1 (
        .CK(CK), .RN(RN), .sw_req(1'b0), .sw_mask(1'b0),
        .sw_ack(u1_ack), .sw_err(u1_err), .rn_out(u1_rn), .all_released(u1_all)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Timeline model: each domain has the edge at which it is next out of reset.
    int cyc      = 0;
    bit in_reset = 1'b1;
    int rel_t [N];
    int done_t   = BIG;
    bit ack_at [int];
    bit err_at [int];

    initial begin
        for (int k = 0; k < N; k++) rel_t[k] = BIG;
    end

    always @(negedge RN) begin
        in_reset = 1'b1;
        for (int k = 0; k < N; k++) rel_t[k] = BIG;
        done_t = BIG;
        ack_at.delete();
        err_at.delete();
    end

    always @(posedge CK) begin
        int t, last;
        cyc++;
        if (RN) begin
            if (in_reset) begin
                in_reset = 1'b0;
                for (int k = 0; k < N; k++) rel_t[k] = cyc + SYNC + 1 + k * GAP;
                done_t = cyc + SYNC + 1 + (N - 1) * GAP + 1;
            end
            if (sw_req) begin
                if (cyc > done_t) begin
                    if (sw_mask == '0) begin
                        ack_at[cyc + 1] = 1'b1;
                    end else begin
                        t    = cyc + HOLD;
                        last = t;
                        for (int k = 0; k < N; k++) begin
                            if (sw_mask[k]) begin
                                rel_t[k] = t;
                                last     = t;
                                t        = t + GAP;
                            end
                        end
                        done_t = last + 1;
                        ack_at[last + 1] = 1'b1;
                    end
                end else begin
                    err_at[cyc + 1] = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge CK) begin
        logic [N-1:0] e;
        for (int k = 0; k < N; k++) e[k] = (cyc >= rel_t[k]);
        check("rn_out", 32'(rn_out), 32'(e));
        check("all_released", 32'(all_released), 32'(cyc >= done_t));
        check("sw_ack", 32'(sw_ack), 32'(ack_at.exists(cyc)));
        check("sw_err", 32'(sw_err), 32'(err_at.exists(cyc)));
    end

    task automatic at_edge(input int x);
        while (cyc < x) @(negedge CK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, s, z, e1, e2;
        RN = 1'b1; sw_req = 1'b0; sw_mask = '0;
        #1 RN = 1'b0;
        repeat (3) @(negedge CK);
        #1;
        check("reset rn_out", 32'(rn_out), 32'h0);
        check("reset all_released", 32'(all_released), 32'h0);
        check("reset u1_rn", 32'(u1_rn), 32'h0);

        @(negedge CK); #2 RN = 1'b1;
        e0 = cyc + 1;
        at_edge(e0 + 3);  check("pu d0", 32'(rn_out), 32'h1); check("u1 rn e3", 32'(u1_rn), 32'h0);
        at_edge(e0 + 4);  check("u1 rn e4", 32'(u1_rn), 32'h1); check("u1 all e4", 32'(u1_all), 32'h0);
        at_edge(e0 + 5);  check("u1 all e5", 32'(u1_all), 32'h1);
        at_edge(e0 + 7);  check("pu d1", 32'(rn_out), 32'h3);
        at_edge(e0 + 8);  sw_req = 1'b1; sw_mask = 4'b0110;
        at_edge(e0 + 9);  sw_req = 1'b0; sw_mask = '0;
        at_edge(e0 + 10); check("err pulse", 32'(sw_err), 32'h1);
        at_edge(e0 + 11); check("err width", 32'(sw_err), 32'h0);
        at_edge(e0 + 15); check("pu d3", 32'(rn_out), 32'hF); check("pu all early", 32'(all_released), 32'h0);
        at_edge(e0 + 16); check("pu all", 32'(all_released), 32'h1);

        at_edge(e0 + 20); sw_req = 1'b1; sw_mask = 4'b1010;
        s = cyc + 1;
        at_edge(s);      sw_req = 1'b0; sw_mask = '0;
        check("sw clear", 32'(rn_out), 32'h5); check("sw all drop", 32'(all_released), 32'h0);
        at_edge(s + 3);  check("sw hold", 32'(rn_out), 32'h5);
        at_edge(s + 4);  check("sw d1", 32'(rn_out), 32'h7);
        at_edge(s + 7);  check("sw gap", 32'(rn_out), 32'h7);
        at_edge(s + 8);  check("sw d3", 32'(rn_out), 32'hF); check("sw all early", 32'(all_released), 32'h0);
        at_edge(s + 9);  check("sw ack", 32'(sw_ack), 32'h1); check("sw all", 32'(all_released), 32'h1);
        at_edge(s + 10); check("sw ack width", 32'(sw_ack), 32'h0);

        at_edge(s + 12); sw_req = 1'b1; sw_mask = '0;
        z = cyc + 1;
        at_edge(z);      sw_req = 1'b0;
        check("zero no ack yet", 32'(sw_ack), 32'h0); check("zero all", 32'(all_released), 32'h1);
        at_edge(z + 1);  check("zero ack", 32'(sw_ack), 32'h1); check("zero rn_out", 32'(rn_out), 32'hF);
        at_edge(z + 2);  check("zero ack width", 32'(sw_ack), 32'h0);

        at_edge(z + 5);  #2 RN = 1'b0;
        @(negedge CK);   #2 RN = 1'b1;
        e1 = cyc + 1;
        at_edge(e1 + 8); check("abort before", 32'(rn_out), 32'h3);
        #2 RN = 1'b0;
        #1 check("abort rn_out", 32'(rn_out), 32'h0); check("abort all", 32'(all_released), 32'h0);
        @(negedge CK);   #2 RN = 1'b1;
        e2 = cyc + 1;
        at_edge(e2 + 2);  check("restart e2", 32'(rn_out), 32'h0);
        at_edge(e2 + 3);  check("restart d0", 32'(rn_out), 32'h1);
        at_edge(e2 + 16); check("restart all", 32'(all_released), 32'h1);

        for (int i = 0; i < 800; i++) begin
            @(negedge CK);
            sw_req  = ($urandom_range(0, 5) == 0);
            sw_mask = 4'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                #2 RN = 1'b0;
                @(negedge CK);
                #2 RN = 1'b1;
            end
        end
        @(negedge CK);
        sw_req = 1'b0; sw_mask = '0; RN = 1'b1;
        repeat (40) @(negedge CK);
        check("final rn_out", 32'(rn_out), 32'hF);
        check("final all", 32'(all_released), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
